// File: rtl/adder_cpe_pkg.sv
// Shared types and defaults for the adder + CPE datapath sequencer.
// Holds the controller state enum, default widths and the data-field slice.
package adder_cpe_pkg;

    localparam int NBIT_DEF  = 7;
    localparam int NCODE_DEF = 15;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        CORRECT,
        DONE
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
// Ports: clk, rst_n (async low), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/adder_cpe_ctrl.sv
// Sequencer for the adder/CPE chain: operand handshake, corrector launch
// with timeout, result handshake and saturating error/failure statistics.
module adder_cpe_ctrl
    import adder_cpe_pkg::*;
#(
    parameter int NBIT    = NBIT_DEF,
    parameter int NCODE   = NCODE_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBIT-1:0]  in_a,
    input  logic [NBIT-1:0]  in_b,
    output logic [NBIT-1:0]  dp_a,
    output logic [NBIT-1:0]  dp_b,
    input  logic [NCODE-1:0] dp_code,
    input  logic             det_error,
    output logic             cor_start,
    input  logic             cor_ready,
    input  logic [NCODE-1:0] cor_ccw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBIT-1:0]  out_sum,
    output logic             out_corrected,
    output logic             out_fail,
    output logic [CNTW-1:0]  err_count,
    output logic [CNTW-1:0]  fail_count
);

    localparam int WW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nx;
    logic [WW-1:0]   wait_cnt;
    logic [NBIT-1:0] code_data;
    logic            accept;
    logic            timeout_hit;
    logic            err_inc;
    logic            fail_inc;
    logic            unused_bits;

    // Only the data field of either codeword is ever returned.
    assign unused_bits = ^{dp_code[NCODE-1:DATA_LSB+NBIT],
                           cor_ccw[NCODE-1:DATA_LSB+NBIT]};

    assign accept      = (state == IDLE) && in_ready && in_valid;
    // wait_cnt holds completed CORRECT cycles, so this is the last one.
    assign timeout_hit = (wait_cnt == WW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        err_inc  = 1'b0;
        fail_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = EVAL;
            end
            EVAL: begin
                if (det_error) begin
                    state_nx = CORRECT;
                    err_inc  = 1'b1;
                end else begin
                    state_nx = DONE;
                end
            end
            CORRECT: begin
                // A late cor_ready still beats the timeout.
                if (cor_ready) begin
                    state_nx = DONE;
                end else if (timeout_hit) begin
                    state_nx = DONE;
                    fail_inc = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            cor_start     <= 1'b0;
            dp_a          <= '0;
            dp_b          <= '0;
            code_data     <= '0;
            wait_cnt      <= '0;
            out_sum       <= '0;
            out_corrected <= 1'b0;
            out_fail      <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            cor_start <= (state == EVAL) && det_error;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dp_a <= in_a;
                        dp_b <= in_b;
                    end
                end
                EVAL: begin
                    code_data <= dp_code[DATA_LSB +: NBIT];
                    wait_cnt  <= '0;
                    if (!det_error) begin
                        out_sum       <= dp_code[DATA_LSB +: NBIT];
                        out_corrected <= 1'b0;
                        out_fail      <= 1'b0;
                    end
                end
                CORRECT: begin
                    if (cor_ready) begin
                        out_sum       <= cor_ccw[DATA_LSB +: NBIT];
                        out_corrected <= 1'b1;
                        out_fail      <= 1'b0;
                    end else if (timeout_hit) begin
                        out_sum       <= code_data;
                        out_corrected <= 1'b0;
                        out_fail      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNTW)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (err_count)
    );

    sat_counter #(.W(CNTW)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fail_inc),
        .count (fail_count)
    );

endmodule

// File: tb/tb_adder_cpe_ctrl.sv
// Scoreboard bench for adder_cpe_ctrl with a behavioural adder/detector
// and a scripted corrector. Latencies are counted from the stimulus edge.
module tb_adder_cpe_ctrl;

    localparam int NBIT  = 7;
    localparam int NCODE = 15;
    localparam int TO    = 16;
    localparam int CNTW  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NBIT-1:0]  in_a, in_b;
    logic [NBIT-1:0]  dp_a, dp_b;
    logic [NCODE-1:0] dp_code;
    logic             det_error;
    logic             cor_start;
    logic             cor_ready;
    logic [NCODE-1:0] cor_ccw;
    logic             out_valid;
    logic             out_ready;
    logic [NBIT-1:0]  out_sum;
    logic             out_corrected;
    logic             out_fail;
    logic [CNTW-1:0]  err_count, fail_count;

    logic             err_mode;
    logic [NBIT-1:0]  sum_raw;

    typedef struct {
        logic [NBIT-1:0] sum;
        logic            corr;
        logic            fail;
        int              lat;
        int              issue;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   cs_count = 0;
    bit   seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: sum in the data field, one bit flipped on error.
    assign sum_raw   = dp_a + dp_b;
    assign dp_code   = {8'hA5, sum_raw ^ {6'b0, err_mode}};
    assign det_error = err_mode;

    adder_cpe_ctrl #(
        .NBIT(NBIT), .NCODE(NCODE), .TIMEOUT(TO), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_code(dp_code), .det_error(det_error),
        .cor_start(cor_start), .cor_ready(cor_ready), .cor_ccw(cor_ccw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_corrected(out_corrected),
        .out_fail(out_fail),
        .err_count(err_count), .fail_count(fail_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: one scoreboard pop per result presented.
    always @(negedge clk) begin
        if (cor_start) cs_count++;
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid && !seen) begin
            seen = 1;
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_sum", int'(out_sum), int'(e.sum));
                check("out_corrected", int'(out_corrected), int'(e.corr));
                check("out_fail", int'(out_fail), int'(e.fail));
                check("latency", cyc - e.issue, e.lat);
            end
        end else if (!out_valid) begin
            seen = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                         input logic em, input logic [NBIT-1:0] esum,
                         input logic ec, input logic ef, input int elat);
        wait_idle();
        err_mode = em;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        q.push_back('{esum, ec, ef, elat, cyc});
        cs_count = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for cor_start, then raises cor_ready in CORRECT cycle k (0: never).
    task automatic corr(input int k, input logic [NBIT-1:0] d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cor_start && n < 10);
        if (!cor_start) check("cor_start_seen", 0, 1);
        if (k == 0) return;
        repeat (k - 1) @(posedge clk);
        #1;
        cor_ready = 1'b1;
        cor_ccw   = {8'h3C, d};
        @(posedge clk);
        #1;
        cor_ready = 1'b0;
    endtask

    task automatic finish_op(input int ecs, input int eerr, input int efail);
        wait_idle();
        check("cor_start_pulses", cs_count, ecs);
        check("err_count", int'(err_count), eerr);
        check("fail_count", int'(fail_count), efail);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        cor_ready = 1'b0;
        cor_ccw   = '0;
        out_ready = 1'b1;
        err_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_fail_count", int'(fail_count), 0);
        rst_n = 1'b1;

        // Plain additions, carry dropped in the second.
        issue(7'd5, 7'd9, 1'b0, 7'd14, 1'b0, 1'b0, 2);
        finish_op(0, 0, 0);
        issue(7'd100, 7'd50, 1'b0, 7'd22, 1'b0, 1'b0, 2);
        finish_op(0, 0, 0);

        // Corrected after three CORRECT cycles.
        issue(7'd3, 7'd4, 1'b1, 7'h16, 1'b1, 1'b0, 5);
        corr(3, 7'h16);
        finish_op(1, 1, 0);

        // Corrector silent: timeout returns the flipped data field 30^1.
        issue(7'd10, 7'd20, 1'b1, 7'd31, 1'b0, 1'b1, 2 + TO);
        corr(0, 7'h00);
        finish_op(1, 2, 1);

        // cor_ready in the final allowed cycle wins over timeout.
        issue(7'd1, 7'd1, 1'b1, 7'h55, 1'b1, 1'b0, 2 + TO);
        corr(TO, 7'h55);
        finish_op(1, 3, 1);

        // Consumer stalls 5 cycles: result held, no new acceptance.
        out_ready = 1'b0;
        issue(7'd60, 7'd70, 1'b0, 7'd2, 1'b0, 1'b0, 2);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        repeat (5) begin
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_out_sum", int'(out_sum), 2);
            check("stall_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        finish_op(0, 3, 1);

        // Asynchronous reset in the middle of CORRECT.
        issue(7'd10, 7'd20, 1'b1, 7'd31, 1'b0, 1'b1, 2 + TO);
        corr(0, 7'h00);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        err_mode = 1'b0;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_cor_start", int'(cor_start), 0);
        check("mid_rst_out_fail", int'(out_fail), 0);
        check("mid_rst_dp_a", int'(dp_a), 0);
        check("mid_rst_err_count", int'(err_count), 0);
        check("mid_rst_fail_count", int'(fail_count), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cs_count = 0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        repeat (TO + 4) @(posedge clk);
        #1;
        check("post_rst_no_cor_start", cs_count, 0);
        check("post_rst_out_valid", int'(out_valid), 0);

        // 300 corrected errors: err_count must stop at 255.
        for (int i = 0; i < 300; i++) begin
            logic [NBIT-1:0] d;
            d = 7'(i);
            issue(7'd7, 7'd8, 1'b1, d, 1'b1, 1'b0, 3);
            corr(1, d);
        end
        finish_op(1, 255, 0);
        check("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
